// File: rtl/rtc_pkg.sv
// Shared RTC field definitions: bus-writer FSM states, register map, BCD helper.
// Imported by every field instance and by the init sequencer.
package rtc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_A_SETUP,
      ST_A_STROBE,
      ST_A_HOLD,
      ST_D_SETUP,
      ST_D_STROBE,
      ST_D_HOLD,
      ST_FIN
   } wr_state_e;

   localparam logic [7:0] RTC_ADDR_SEC   = 8'h21;
   localparam logic [7:0] RTC_ADDR_MIN   = 8'h22;
   localparam logic [7:0] RTC_ADDR_HOUR  = 8'h23;
   localparam logic [7:0] RTC_ADDR_DAY   = 8'h24;
   localparam logic [7:0] RTC_ADDR_DATE  = 8'h25;
   localparam logic [7:0] RTC_ADDR_MONTH = 8'h26;
   localparam logic [7:0] RTC_ADDR_YEAR  = 8'h27;

   // Valid for 0..99 only; upper nibble is tens, lower nibble is ones.
   function automatic logic [7:0] bin2bcd(input logic [6:0] value);
      return {4'(value / 7'd10), 4'(value % 7'd10)};
   endfunction

endpackage

// File: rtl/rtc_bus_writer.sv
// Sequences one register write on the RTC multiplexed bus: address phase then
// data phase, each split into setup/strobe/hold sub-phases of T_PHASE cycles.
module rtc_bus_writer
   import rtc_pkg::*;
#(
   parameter int unsigned T_PHASE = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [7:0] i_addr,
   input  logic [7:0] i_data,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_cs_n,
   output logic       o_ad,
   output logic       o_rd_n,
   output logic       o_wr_n,
   output logic [7:0] o_bus,
   output logic       o_bus_oe
);

   localparam logic [3:0] PHASE_LAST = 4'(T_PHASE - 1);

   wr_state_e  r_state;
   wr_state_e  w_next_state;
   logic [3:0] r_phase;
   logic [7:0] r_data;
   logic       w_phase_end;

   assign w_phase_end = (r_phase == PHASE_LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_phase <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_next_state;
         // Phase counter restarts on every state change so each sub-phase is timed alone.
         if (r_state != w_next_state) begin
            r_phase <= '0;
         end else if (r_state != ST_IDLE && r_state != ST_FIN) begin
            r_phase <= r_phase + 4'd1;
         end
         if (r_state == ST_IDLE && i_start) begin
            r_data <= i_data;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:     if (i_start)     w_next_state = ST_A_SETUP;
         ST_A_SETUP:  if (w_phase_end) w_next_state = ST_A_STROBE;
         ST_A_STROBE: if (w_phase_end) w_next_state = ST_A_HOLD;
         ST_A_HOLD:   if (w_phase_end) w_next_state = ST_D_SETUP;
         ST_D_SETUP:  if (w_phase_end) w_next_state = ST_D_STROBE;
         ST_D_STROBE: if (w_phase_end) w_next_state = ST_D_HOLD;
         ST_D_HOLD:   if (w_phase_end) w_next_state = ST_FIN;
         ST_FIN:                       w_next_state = ST_IDLE;
         default:                      w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      o_busy   = (r_state != ST_IDLE);
      o_done   = (r_state == ST_FIN);
      o_cs_n   = 1'b1;
      o_ad     = 1'b1;
      o_rd_n   = 1'b1;
      o_wr_n   = 1'b1;
      o_bus    = '0;
      o_bus_oe = 1'b0;
      case (r_state)
         ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
            o_cs_n   = 1'b0;
            o_ad     = 1'b0;
            o_bus    = i_addr;
            o_bus_oe = 1'b1;
            o_wr_n   = (r_state != ST_A_STROBE);
         end
         ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
            o_cs_n   = 1'b0;
            o_ad     = 1'b1;
            o_bus    = r_data;
            o_bus_oe = 1'b1;
            o_wr_n   = (r_state != ST_D_STROBE);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/rtc_time_field.sv
// One editable RTC time field: wrapping up/down counter with optional 12-hour
// range, registered BCD view, and a bus writer that pushes the value to the RTC.
module rtc_time_field
   import rtc_pkg::*;
#(
   parameter int unsigned MAX_VAL    = 23,
   parameter int unsigned MIN_VAL    = 0,
   parameter int unsigned HOUR_FIELD = 0,
   parameter logic [7:0]  REG_ADDR   = RTC_ADDR_HOUR,
   parameter int unsigned T_PHASE    = 4,
   parameter int unsigned AUTO_WR    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       up,
   input  logic       down,
   input  logic       h12,
   input  logic       wr_req,
   output logic [7:0] field_bcd,
   output logic       busy,
   output logic       done,
   output logic       CS,
   output logic       AD,
   output logic       RD,
   output logic       WR,
   output logic [7:0] bus_out,
   output logic       bus_oe
);

   logic [6:0] r_value;
   logic [7:0] r_bcd;
   logic [6:0] w_next_value;
   logic [6:0] w_lo;
   logic [6:0] w_hi;
   logic       w_h12_mode;
   logic       w_out_of_range;
   logic       w_step_acc;
   logic       w_launch;
   logic       w_busy;

   assign w_h12_mode     = (HOUR_FIELD != 0) && h12;
   assign w_lo           = w_h12_mode ? 7'd1  : 7'(MIN_VAL);
   assign w_hi           = w_h12_mode ? 7'd12 : 7'(MAX_VAL);
   assign w_out_of_range = (r_value < w_lo) || (r_value > w_hi);

   // A range change takes priority over a step so the value never leaves [lo,hi].
   always_comb begin
      w_next_value = r_value;
      w_step_acc   = 1'b0;
      if (w_out_of_range) begin
         w_next_value = w_lo;
      end else if (en && up && !down) begin
         w_step_acc   = 1'b1;
         w_next_value = (r_value == w_hi) ? w_lo : r_value + 7'd1;
      end else if (en && down && !up) begin
         w_step_acc   = 1'b1;
         w_next_value = (r_value == w_lo) ? w_hi : r_value - 7'd1;
      end
   end

   assign w_launch = !w_busy && (wr_req || ((AUTO_WR != 0) && w_step_acc));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_value <= w_lo;
         r_bcd   <= bin2bcd(w_lo);
      end else begin
         r_value <= w_next_value;
         r_bcd   <= bin2bcd(r_value);
      end
   end

   assign field_bcd = r_bcd;
   assign busy      = w_busy;

   // Snapshot uses the post-step value so an auto write carries the new setting.
   rtc_bus_writer #(
      .T_PHASE (T_PHASE)
   ) u_writer (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_start  (w_launch),
      .i_addr   (REG_ADDR),
      .i_data   (bin2bcd(w_next_value)),
      .o_busy   (w_busy),
      .o_done   (done),
      .o_cs_n   (CS),
      .o_ad     (AD),
      .o_rd_n   (RD),
      .o_wr_n   (WR),
      .o_bus    (bus_out),
      .o_bus_oe (bus_oe)
   );

endmodule

// File: tb/tb_rtc_time_field.sv
// Directed bench for rtc_time_field: an hour field (A, manual writes) and a
// minutes-style field (B, auto writes), both with T_PHASE=2.
module tb_rtc_time_field;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic       a_en = 1'b1, a_up = 1'b0, a_down = 1'b0, a_h12 = 1'b0, a_wr_req = 1'b0;
   logic [7:0] a_field_bcd, a_bus_out;
   logic       a_busy, a_done, a_cs, a_ad, a_rd, a_wr, a_bus_oe;

   logic       b_en = 1'b1, b_up = 1'b0, b_down = 1'b0, b_h12 = 1'b0, b_wr_req = 1'b0;
   logic [7:0] b_field_bcd, b_bus_out;
   logic       b_busy, b_done, b_cs, b_ad, b_rd, b_wr, b_bus_oe;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rtc_time_field #(
      .MAX_VAL(23), .MIN_VAL(0), .HOUR_FIELD(1), .REG_ADDR(8'h23), .T_PHASE(2), .AUTO_WR(0)
   ) u_dut_a (
      .clk(clk), .reset(reset), .en(a_en), .up(a_up), .down(a_down), .h12(a_h12),
      .wr_req(a_wr_req), .field_bcd(a_field_bcd), .busy(a_busy), .done(a_done),
      .CS(a_cs), .AD(a_ad), .RD(a_rd), .WR(a_wr), .bus_out(a_bus_out), .bus_oe(a_bus_oe)
   );

   rtc_time_field #(
      .MAX_VAL(59), .MIN_VAL(0), .HOUR_FIELD(0), .REG_ADDR(8'h22), .T_PHASE(2), .AUTO_WR(1)
   ) u_dut_b (
      .clk(clk), .reset(reset), .en(b_en), .up(b_up), .down(b_down), .h12(b_h12),
      .wr_req(b_wr_req), .field_bcd(b_field_bcd), .busy(b_busy), .done(b_done),
      .CS(b_cs), .AD(b_ad), .RD(b_rd), .WR(b_wr), .bus_out(b_bus_out), .bus_oe(b_bus_oe)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse for one cycle, then wait one more so field_bcd reflects the step.
   task automatic a_step(input logic u, input logic d);
      a_up = u;
      a_down = d;
      tick();
      a_up = 1'b0;
      a_down = 1'b0;
      tick();
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   // {CS, AD, RD, WR, bus_oe, busy, done, bus_out}
   function automatic logic [14:0] a_pins();
      return {a_cs, a_ad, a_rd, a_wr, a_bus_oe, a_busy, a_done, a_bus_out};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_cnt;
      int lat;
      logic busy_ok;
      logic data_ok;
      logic [14:0] exp_pins;

      repeat (3) tick();
      reset = 1'b0;
      tick();

      check_eq("rst_bcd_a", a_field_bcd, 8'h00);
      check_eq("rst_pins_a", a_pins(), {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      check_eq("rst_bcd_b", b_field_bcd, 8'h00);
      check_eq("rst_busy_b", b_busy, 1'b0);

      for (int i = 1; i <= 24; i++) begin
         a_step(1'b1, 1'b0);
         check_eq($sformatf("up_%0d", i), a_field_bcd, to_bcd(i % 24));
      end

      a_step(1'b0, 1'b1);
      check_eq("down_wrap", a_field_bcd, 8'h23);
      a_step(1'b1, 1'b1);
      check_eq("up_down_hold", a_field_bcd, 8'h23);
      a_en = 1'b0;
      a_step(1'b1, 1'b0);
      check_eq("en_low_hold", a_field_bcd, 8'h23);
      a_en = 1'b1;
      check_eq("no_auto_write", a_busy, 1'b0);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      a_h12 = 1'b1;
      tick();
      tick();
      check_eq("h12_clamp", a_field_bcd, 8'h01);
      a_step(1'b0, 1'b1);
      check_eq("h12_down_wrap", a_field_bcd, 8'h12);
      a_step(1'b1, 1'b0);
      check_eq("h12_up_wrap", a_field_bcd, 8'h01);
      a_step(1'b0, 1'b1);
      check_eq("h12_back_12", a_field_bcd, 8'h12);
      a_h12 = 1'b0;
      tick();
      tick();
      check_eq("h24_keep_12", a_field_bcd, 8'h12);
      for (int i = 0; i < 5; i++) a_step(1'b1, 1'b0);
      check_eq("value_17", a_field_bcd, 8'h17);

      a_wr_req = 1'b1;
      tick();
      a_wr_req = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         exp_pins = {(c <= 12) ? 1'b0 : 1'b1,
                     (c <= 6) ? 1'b0 : 1'b1,
                     1'b1,
                     (c == 3 || c == 4 || c == 9 || c == 10) ? 1'b0 : 1'b1,
                     (c <= 12) ? 1'b1 : 1'b0,
                     (c <= 13) ? 1'b1 : 1'b0,
                     (c == 13) ? 1'b1 : 1'b0,
                     (c <= 6) ? 8'h23 : ((c <= 12) ? 8'h17 : 8'h00)};
         check_eq($sformatf("wr_cycle_%0d", c), a_pins(), exp_pins);
         tick();
      end

      a_wr_req = 1'b1;
      tick();
      a_wr_req = 1'b0;
      repeat (8) tick();
      check_eq("pre_abort_dstrobe", {a_ad, a_wr}, 2'b10);
      reset = 1'b1;
      tick();
      check_eq("abort_pins", a_pins(), {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      check_eq("abort_bcd", a_field_bcd, 8'h00);
      reset = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (a_done || a_busy) done_cnt++;
      end
      check_eq("abort_no_done", done_cnt, 0);

      a_en = 1'b0;
      a_wr_req = 1'b1;
      tick();
      a_wr_req = 1'b0;
      lat = 0;
      for (int c = 1; c <= 30 && lat == 0; c++) begin
         if (a_done) lat = c;
         else tick();
      end
      check_eq("rewrite_latency", lat, 13);
      a_en = 1'b1;

      done_cnt = 0;
      busy_ok = 1'b1;
      data_ok = 1'b1;
      for (int c = 0; c <= 20; c++) begin
         b_up = (c == 0 || c == 2 || c == 4);
         tick();
         if (c + 1 <= 13 && !b_busy) busy_ok = 1'b0;
         if (b_done) done_cnt++;
         if (b_bus_oe && b_ad && b_bus_out != 8'h01) data_ok = 1'b0;
      end
      b_up = 1'b0;
      check_eq("auto_one_write", done_cnt, 1);
      check_eq("auto_busy_held", busy_ok, 1'b1);
      check_eq("auto_snapshot", data_ok, 1'b1);
      check_eq("auto_bcd_03", b_field_bcd, 8'h03);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
